// File: rtl/burst_request_splitter.sv
// Splits a transfer (start beat address + beat count) into bursts that respect
// a maximum length and never cross a BOUNDARY_BEATS-aligned address.
module burst_request_splitter #(
    parameter int ADDR_WIDTH       = 32,
    parameter int SIZE_WIDTH       = 16,
    parameter int MAX_BURST_LENGTH = 4,
    parameter int BOUNDARY_BEATS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [SIZE_WIDTH-1:0] s_size,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [7:0]            m_length,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last_burst,
    output logic                  busy
);

    // state | meaning
    // IDLE  | no transfer held, s_ready high
    // SPLIT | transfer held, a burst is always presented on m_*
    typedef enum logic {IDLE, SPLIT} state_t;

    localparam int CNT_W = SIZE_WIDTH + 1;
    localparam int CW    = (CNT_W > 33) ? CNT_W : 33;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [CNT_W-1:0]      remaining;

    logic [ADDR_WIDTH-1:0] src_addr;
    logic [CNT_W-1:0]      src_rem;
    logic [CW-1:0]         to_bound;
    logic [CW-1:0]         beats;
    logic                  load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (s_valid) state_nx = SPLIT;
            SPLIT:   if (m_ready && m_last_burst) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == IDLE);
        busy    = (state == SPLIT);
        m_valid = (state == SPLIT);
        load    = ((state == IDLE) && s_valid) ||
                  ((state == SPLIT) && m_ready && !m_last_burst);
    end

    // The first burst is sized straight from the request so it can be
    // presented one cycle after acceptance; later bursts use the held state.
    always_comb begin
        if (state == IDLE) begin
            src_addr = s_addr;
            src_rem  = {1'b0, s_size} + {{SIZE_WIDTH{1'b0}}, 1'b1};
        end else begin
            src_addr = next_addr;
            src_rem  = remaining;
        end
        to_bound = CW'(BOUNDARY_BEATS) - (CW'(src_addr) & CW'(BOUNDARY_BEATS - 1));
        beats    = CW'(src_rem);
        if (beats > CW'(MAX_BURST_LENGTH)) beats = CW'(MAX_BURST_LENGTH);
        if (beats > to_bound)              beats = to_bound;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr       <= '0;
            m_length     <= '0;
            m_last_burst <= 1'b0;
            next_addr    <= '0;
            remaining    <= '0;
        end else if (load) begin
            m_addr       <= src_addr;
            m_length     <= 8'(beats - CW'(1));
            m_last_burst <= (src_rem == CNT_W'(beats));
            next_addr    <= src_addr + ADDR_WIDTH'(beats);
            remaining    <= src_rem - CNT_W'(beats);
        end
    end

endmodule

// File: tb/tb_burst_request_splitter.sv
// Scoreboard bench for burst_request_splitter: expected bursts are queued when
// a transfer is issued and compared as the DUT presents them.
module tb_burst_request_splitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_addr = '0;
    logic [15:0] s_size = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_addr;
    logic [7:0]  m_length;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last_burst;
    logic        busy;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  l;
        logic        last;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    burst_request_splitter dut (
        .clk(clk), .rst(rst),
        .s_addr(s_addr), .s_size(s_size), .s_valid(s_valid), .s_ready(s_ready),
        .m_addr(m_addr), .m_length(m_length), .m_valid(m_valid), .m_ready(m_ready),
        .m_last_burst(m_last_burst), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void push(input logic [31:0] a, input logic [7:0] l, input logic last);
        exp_t e;
        e.a = a; e.l = l; e.last = last;
        q.push_back(e);
    endfunction

    // Reference split for randomized transfers; returns number of bursts.
    function automatic int push_model(input logic [31:0] addr, input logic [15:0] size);
        int rem = int'(size) + 1;
        logic [31:0] a = addr;
        int n = 0;
        while (rem > 0) begin
            int b = rem;
            int tb = 16 - int'(a % 32'd16);
            if (b > 4)  b = 4;
            if (b > tb) b = tb;
            push(a, 8'(b - 1), rem == b);
            a = a + 32'(b);
            rem = rem - b;
            n++;
        end
        return n;
    endfunction

    task automatic send(input logic [31:0] a, input logic [15:0] sz, input bit keep);
        @(negedge clk);
        s_addr = a; s_size = sz; s_valid = 1'b1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: s_ready=%b want 1", s_ready);
        end
        @(posedge clk);
        #1;
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int stall_at, input int stall_len, input bit check_idle);
        int got = 0;
        int cyc = 0;
        exp_t e;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            m_ready = !(cyc > stall_at && cyc <= stall_at + stall_len);
            total++;
            if (m_valid !== 1'b1) begin
                bad++;
                $display("FAIL burst_valid: m_valid=%b want 1 (cycle %0d)", m_valid, cyc);
            end else begin
                e = q[0];
                total++;
                if (m_addr !== e.a || m_length !== e.l || m_last_burst !== e.last) begin
                    bad++;
                    $display("FAIL burst_data: got addr=%h len=%0d last=%b want addr=%h len=%0d last=%b",
                             m_addr, m_length, m_last_burst, e.a, e.l, e.last);
                end
                total++;
                if (s_ready !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL split_flags: s_ready=%b busy=%b want 0 1", s_ready, busy);
                end
                if (m_ready) begin
                    void'(q.pop_front());
                    got++;
                end
            end
        end
        if (got < n) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d bursts want %0d", got, n);
        end
        @(negedge clk);
        m_ready = 1'b0;
        if (check_idle) begin
            total++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_after: m_valid=%b s_ready=%b busy=%b want 0 1 0", m_valid, s_ready, busy);
            end
        end
    endtask

    task automatic test_reset;
        #3;
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 ||
            m_addr !== 32'h0 || m_length !== 8'h0 || m_last_burst !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: s_ready=%b m_valid=%b busy=%b addr=%h len=%0d last=%b",
                     s_ready, m_valid, busy, m_addr, m_length, m_last_burst);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single;
        push(32'h100, 8'd0, 1'b1);
        send(32'h100, 16'd0, 1'b0);
        drain(1, 0, 0, 1'b1);
    endtask

    task automatic test_multi;
        push(32'h100, 8'd3, 1'b0);
        push(32'h104, 8'd3, 1'b0);
        push(32'h108, 8'd1, 1'b1);
        send(32'h100, 16'd9, 1'b0);
        drain(3, 0, 0, 1'b1);
    endtask

    task automatic test_boundary;
        push(32'h10E, 8'd1, 1'b0);
        push(32'h110, 8'd3, 1'b1);
        send(32'h10E, 16'd5, 1'b0);
        drain(2, 0, 0, 1'b1);
    endtask

    task automatic test_stall;
        push(32'h100, 8'd3, 1'b0);
        push(32'h104, 8'd3, 1'b0);
        push(32'h108, 8'd1, 1'b1);
        send(32'h100, 16'd9, 1'b0);
        drain(3, 1, 5, 1'b1);
    endtask

    task automatic test_wrap;
        push(32'hFFFFFFFE, 8'd1, 1'b0);
        push(32'h00000000, 8'd1, 1'b1);
        send(32'hFFFFFFFE, 16'd3, 1'b0);
        drain(2, 0, 0, 1'b1);
    endtask

    task automatic test_back_to_back;
        push(32'h100, 8'd0, 1'b1);
        send(32'h100, 16'd0, 1'b1);
        s_addr = 32'h300; s_size = 16'd4;
        push(32'h300, 8'd3, 1'b0);
        push(32'h304, 8'd0, 1'b1);
        drain(1, 0, 0, 1'b1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        drain(2, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid;
        push(32'h100, 8'd3, 1'b0);
        send(32'h100, 16'd9, 1'b0);
        drain(1, 0, 0, 1'b0);
        total++;
        if (m_valid !== 1'b1 || m_addr !== 32'h104) begin
            bad++;
            $display("FAIL second_burst: m_valid=%b addr=%h want 1 104", m_valid, m_addr);
        end
        rst = 1'b1;
        #1;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || m_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_async: m_valid=%b s_ready=%b busy=%b addr=%h", m_valid, s_ready, busy, m_addr);
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (m_valid !== 1'b0) begin
                bad++;
                $display("FAIL abandoned: m_valid=%b want 0", m_valid);
            end
        end
        m_ready = 1'b0;
        push(32'h200, 8'd3, 1'b1);
        send(32'h200, 16'd3, 1'b0);
        drain(1, 0, 0, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [15:0] sz;
            int n;
            a  = {$urandom_range(0, 1) ? 28'hFFFFFFF : 28'(i), 4'($urandom_range(0, 15))};
            sz = 16'($urandom_range(0, 20));
            n  = push_model(a, sz);
            send(a, sz, 1'b0);
            drain(n, $urandom_range(0, 3), $urandom_range(0, 4), 1'b1);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_multi;
        test_boundary;
        test_stall;
        test_wrap;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
